condunit_banked: RTL and testbench

- Next-generation conditional-execution unit for the single-cycle core.
- Holds per-context NZCV flag registers (NCTX hardware contexts) with partial-group flag writes.
- Evaluates the 4-bit condition field against the selected context's stored flags and gates PCSrc, RegWrite and MemWrite.
- Keeps saturating per-context executed/skipped instruction counters for debug and performance visibility.

---
 rtl/condunit_banked.sv | 177 +++++++++++++++++
 tb/tb_condunit_banked.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/condunit_banked.sv
// condunit_banked
// ---------------------------------------------------------------------------
// Conditional-execution unit with NCTX banked NZCV flag registers.
// The condition field is evaluated against the stored flags of the selected
// context (no forwarding from ALUFlags). The result gates the PC, register
// file and memory write enables. Flags are written in two independent groups
// (N,Z and C,V). Each context also has a pair of saturating debug counters
// that count executed and skipped instructions.
//
// Ports
//   clk       in   core clock, state updates on rising edge
//   reset     in   asynchronous active-low reset of all banks and counters
//   en        in   instruction valid; gates flag and counter updates
//   ctx       in   context select (values >= NCTX are a no-op)
//   Cond      in   4-bit condition field
//   ALUFlags  in   {N,Z,C,V} from the current instruction
//   FlagW     in   [1] write N,Z group, [0] write C,V group
//   PCS       in   decoder PC write
//   RegW      in   decoder register-file write
//   MemW      in   decoder memory write
//   NoWrite   in   compare-type instruction, suppresses RegWrite
//   cnt_clr   in   synchronous clear of both counters of ctx (ignores en)
//   CondEx    out  condition result (combinational)
//   PCSrc     out  PCS & CondEx
//   RegWrite  out  RegW & CondEx & ~NoWrite
//   MemWrite  out  MemW & CondEx
//   Flags     out  stored {N,Z,C,V} of ctx
//   ExecCnt   out  executed-instruction count of ctx
//   SkipCnt   out  skipped-instruction count of ctx
// ---------------------------------------------------------------------------
module condunit_banked #(
  parameter int NCTX     = 4,
  parameter int CNT_W    = 16,
  parameter bit NEVER_EN = 1'b1,
  parameter int CTX_W    = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CTX_W-1:0] ctx,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             cnt_clr,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SkipCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Full condition table. Code 4'b1111 is either "never" or the legacy
  // second "always" encoding, selected at elaboration time.
  function automatic logic cond_eval(input logic [3:0] cond,
                                     input logic [3:0] f,
                                     input logic       never_en);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~(c & ~z);
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = ~(~z & (n == v));
      4'b1110: r = 1'b1;
      4'b1111: r = ~never_en;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [3:0]       flags_r [NCTX];
  logic [CNT_W-1:0] exec_r  [NCTX];
  logic [CNT_W-1:0] skip_r  [NCTX];

  logic [CTX_W-1:0] idx_s;
  logic             ctx_valid_s;
  logic [3:0]       sel_flags_s;
  logic             cond_ex_s;
  logic [CNT_W-1:0] sel_exec_s;
  logic [CNT_W-1:0] sel_skip_s;

  // With a single context the select input is ignored entirely.
  assign idx_s       = (NCTX == 1) ? {CTX_W{1'b0}} : ctx;
  assign ctx_valid_s = (NCTX == 1) ? 1'b1 : (int'(ctx) < NCTX);

  // Read side: an illegal context reads as all-zero flags and counters and
  // never executes.
  always_comb begin
    sel_flags_s = 4'b0000;
    sel_exec_s  = {CNT_W{1'b0}};
    sel_skip_s  = {CNT_W{1'b0}};
    cond_ex_s   = 1'b0;
    if (ctx_valid_s) begin
      sel_flags_s = flags_r[idx_s];
      sel_exec_s  = exec_r[idx_s];
      sel_skip_s  = skip_r[idx_s];
      cond_ex_s   = cond_eval(Cond, flags_r[idx_s], NEVER_EN);
    end else begin
      sel_flags_s = 4'b0000;
      sel_exec_s  = {CNT_W{1'b0}};
      sel_skip_s  = {CNT_W{1'b0}};
      cond_ex_s   = 1'b0;
    end
  end

  assign CondEx   = cond_ex_s;
  assign PCSrc    = PCS & cond_ex_s;
  assign RegWrite = RegW & cond_ex_s & ~NoWrite;
  assign MemWrite = MemW & cond_ex_s;
  assign Flags    = sel_flags_s;
  assign ExecCnt  = sel_exec_s;
  assign SkipCnt  = sel_skip_s;

  // Flag banks: only an executed instruction on a legal context writes, and
  // the two groups are loaded independently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCTX; i++) begin
        flags_r[i] <= 4'b0000;
      end
    end else if (en && cond_ex_s) begin
      if (FlagW[1]) begin
        flags_r[idx_s][3:2] <= ALUFlags[3:2];
      end
      if (FlagW[0]) begin
        flags_r[idx_s][1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Debug counters: clear wins over an increment and works without en;
  // increments saturate instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCTX; i++) begin
        exec_r[i] <= {CNT_W{1'b0}};
        skip_r[i] <= {CNT_W{1'b0}};
      end
    end else if (cnt_clr && ctx_valid_s) begin
      exec_r[idx_s] <= {CNT_W{1'b0}};
      skip_r[idx_s] <= {CNT_W{1'b0}};
    end else if (en && ctx_valid_s) begin
      if (cond_ex_s) begin
        if (exec_r[idx_s] != CNT_MAX) begin
          exec_r[idx_s] <= exec_r[idx_s] + CNT_W'(1);
        end
      end else begin
        if (skip_r[idx_s] != CNT_MAX) begin
          skip_r[idx_s] <= skip_r[idx_s] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_condunit_banked.sv
// Testbench for condunit_banked: directed sequence followed by random
// traffic, checked against a behavioural model through a scoreboard queue.
module tb_condunit_banked;

  localparam int NCTX     = 4;
  localparam int CNT_W    = 4;
  localparam bit NEVER_EN = 1'b1;
  localparam int CTX_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [CTX_W-1:0] ctx;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS, RegW, MemW, NoWrite, cnt_clr;
  logic             CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCnt, SkipCnt;

  always #5 clk = ~clk;

  condunit_banked #(.NCTX(NCTX), .CNT_W(CNT_W), .NEVER_EN(NEVER_EN)) dut (
    .clk(clk), .reset(reset), .en(en), .ctx(ctx), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .cnt_clr(cnt_clr),
    .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .ExecCnt(ExecCnt), .SkipCnt(SkipCnt)
  );

  typedef struct packed {
    logic             ce;
    logic             pc;
    logic             rw;
    logic             mw;
    logic [3:0]       fl;
    logic [CNT_W-1:0] ex;
    logic [CNT_W-1:0] sk;
  } exp_t;

  exp_t sbq[$];
  int   total  = 0;
  int   bad    = 0;
  int   pushed = 0;
  int   popped = 0;

  // Reference state: flags as 4-bit {N,Z,C,V}, counters as plain integers.
  logic [3:0] m_fl[NCTX];
  int         m_ex[NCTX];
  int         m_sk[NCTX];

  function automatic void m_reset();
    for (int i = 0; i < NCTX; i++) begin
      m_fl[i] = 4'b0000;
      m_ex[i] = 0;
      m_sk[i] = 0;
    end
  endfunction

  // Conditions come in pairs: odd code = inverse of the even one.
  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1111) return !NEVER_EN;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, expv, $time);
    end
  endtask

  // One instruction slot: drive inputs, push the expected response, then
  // advance the model to the state after the next rising edge.
  task automatic step(input logic rst_i, input logic en_i,
                      input logic [CTX_W-1:0] ctx_i, input logic [3:0] cond_i,
                      input logic [3:0] alu_i, input logic [1:0] fw_i,
                      input logic pcs_i, input logic regw_i, input logic memw_i,
                      input logic nw_i, input logic clr_i);
    exp_t e;
    logic ce;
    @(posedge clk);
    #1;
    reset = rst_i; en = en_i; ctx = ctx_i; Cond = cond_i; ALUFlags = alu_i;
    FlagW = fw_i; PCS = pcs_i; RegW = regw_i; MemW = memw_i;
    NoWrite = nw_i; cnt_clr = clr_i;
    if (!rst_i) m_reset();
    ce   = m_cond(cond_i, m_fl[ctx_i]);
    e.ce = ce;
    e.pc = pcs_i & ce;
    e.rw = regw_i & ce & ~nw_i;
    e.mw = memw_i & ce;
    e.fl = m_fl[ctx_i];
    e.ex = CNT_W'(m_ex[ctx_i]);
    e.sk = CNT_W'(m_sk[ctx_i]);
    sbq.push_back(e);
    pushed++;
    if (rst_i) begin
      if (en_i && ce) begin
        if (fw_i[1]) m_fl[ctx_i][3:2] = alu_i[3:2];
        if (fw_i[0]) m_fl[ctx_i][1:0] = alu_i[1:0];
      end
      if (clr_i) begin
        m_ex[ctx_i] = 0;
        m_sk[ctx_i] = 0;
      end else if (en_i) begin
        if (ce) m_ex[ctx_i] = (m_ex[ctx_i] < CNT_MAX) ? m_ex[ctx_i] + 1 : CNT_MAX;
        else    m_sk[ctx_i] = (m_sk[ctx_i] < CNT_MAX) ? m_sk[ctx_i] + 1 : CNT_MAX;
      end
    end
  endtask

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        popped++;
        chk("CondEx",   int'(CondEx),   int'(e.ce));
        chk("PCSrc",    int'(PCSrc),    int'(e.pc));
        chk("RegWrite", int'(RegWrite), int'(e.rw));
        chk("MemWrite", int'(MemWrite), int'(e.mw));
        chk("Flags",    int'(Flags),    int'(e.fl));
        chk("ExecCnt",  int'(ExecCnt),  int'(e.ex));
        chk("SkipCnt",  int'(SkipCnt),  int'(e.sk));
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; ctx = '0; Cond = 4'b0000; ALUFlags = 4'b0000;
    FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    cnt_clr = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);

    // Reset state: EQ with zero flags is false, all gates low.
    step(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // Full flag write on ctx2, then observe ctx2 and ctx0.
    step(1'b1, 1'b1, 2'd2, 4'b1110, 4'b0100, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // Partial write of the C,V group, then HI and GE.
    step(1'b1, 1'b1, 2'd2, 4'b1110, 4'b1011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd2, 4'b1000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd2, 4'b1010, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // Skipped instruction on ctx1, then a compare that still writes flags.
    step(1'b1, 1'b1, 2'd1, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd1, 4'b1110, 4'b0010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd1, 4'b0010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Saturation on ctx3, clear with en=1, then the "never" code.
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 2'd3, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd3, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 2'd3, 4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd3, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Async reset with ctx0 flags at 1001; the edge during reset is lost.
    step(1'b1, 1'b1, 2'd0, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 4'b0110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 4'b1110, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd3, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic across all contexts and condition codes.
    for (int i = 0; i < 400; i++) begin
      step(1'b1,
           1'(($urandom_range(0, 3) != 0)),
           CTX_W'($urandom_range(0, NCTX - 1)),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'(($urandom_range(0, 15) == 0)));
    end

    repeat (2) @(posedge clk);
    chk("sb_drain", sbq.size(), 0);
    chk("sb_count", popped, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
